mmio_periph: RTL and testbench
==============================

MMIO_PERIPH -- requirements
Module: mmio_periph

Interface
REQ-001 SHALL have ports: clk input 1 (clock); reset input 1 (asynchronous, active-high).
REQ-002 SHALL have ports: adr input 32 and writedata input 32 (CPU byte address and store data); memwrite input 1 (CPU store strobe, high one cycle per store).
REQ-003 SHALL have ports: readdata output 32 (data to CPU); mem_rdata input 32 (data memory read word); mem_we output 1 (data memory write enable).
REQ-004 SHALL have ports: led output 8 (LED register); tx_data output 8, tx_valid output 1, tx_ready input 1 (byte stream to consumer); irq output 1 (timer interrupt).

Function
REQ-005 SHALL decode io_sel = (adr[31:8] == 24'hFFFFFF); register offset = adr[7:2]; adr[1:0] ignored.
REQ-006 SHALL drive mem_we = memwrite & ~io_sel, combinationally.
REQ-007 SHALL drive readdata = io_sel ? io_rdata : mem_rdata, combinationally, so that data is valid in the same cycle as adr.
REQ-008 Reads SHALL have no side effects, because the CPU holds adr stable for several cycles.
REQ-009 IO writes SHALL take effect on the posedge clk where memwrite & io_sel = 1.
REQ-010 Register map (offsets are byte offsets):
 - 0x00 LED: read/write; bits[7:0] drive led; bits[31:8] read as 0.
 - 0x04 TXDATA: a write pushes writedata[7:0] into the FIFO; reads return 0.
 - 0x08 STATUS: read only, except as noted. bit0 = empty, bit1 = full, bit2 = tflag, bits[5:3] = count (0-4), other bits 0. Writing with writedata[2] = 1 clears tflag.
 - 0x0C TIMER: read/write; 32-bit count.
 - 0x10 COMPARE: read/write; 32 bits.
 - 0x14 CTRL: read/write; bit0 = ten (timer enable), bit1 = ien (interrupt enable); other bits read 0.
 - All other IO offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-011 The TX FIFO SHALL be 4 entries x 8 bits, with circular read/write pointers and a 3-bit count.
REQ-012 tx_valid SHALL equal (count != 0); tx_data SHALL equal the head entry, driven from registers with no combinational path from tx_ready.
REQ-013 A pop SHALL occur when tx_valid & tx_ready; the head advances on that posedge.
REQ-014 A push when count < 4 SHALL store the byte at the tail and increment count.
REQ-015 A push when count == 4 with no pop in the same cycle SHALL be dropped; FIFO contents and count stay unchanged.
REQ-016 A push and a pop in the same cycle SHALL both occur, and count SHALL be unchanged. This applies when full: the push is accepted.
REQ-017 A push and a pop in the same cycle when empty SHALL NOT occur, because tx_valid = 0; the push alone occurs.
REQ-018 The timer SHALL hold its value when ten = 0.
REQ-019 When ten = 1 and count != COMPARE, the timer SHALL increment by 1 per cycle, wrapping modulo 2^32.
REQ-020 When ten = 1 and count == COMPARE, the next timer value SHALL be 0 and tflag SHALL be set on that posedge.
REQ-021 A CPU write to TIMER SHALL override increment and match-wrap in the same cycle. Match detection and tflag set SHALL still use the pre-write count.
REQ-022 tflag SHALL be sticky. If a set and a STATUS clear occur in the same cycle, the set SHALL win.
REQ-023 irq SHALL equal tflag & ien and SHALL be driven from registers.
REQ-024 Each register write SHALL update only the register addressed.

Reset
REQ-025 On reset assertion, the block SHALL asynchronously set: LED = 0, FIFO empty (pointers 0, count 0), timer = 0, COMPARE = 32'hFFFFFFFF, ten = 0, ien = 0, tflag = 0.
REQ-026 During reset, the outputs SHALL be: led = 0, tx_valid = 0, irq = 0. mem_we and readdata SHALL remain combinational.
REQ-027 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight write.
REQ-028 The first write after reset deassertion SHALL take effect on the first posedge with reset low.

Verification
REQ-029 Decode: read adr 0x00000040 with mem_rdata = 0x12345678 -> readdata = 0x12345678. Store to 0xFFFFFF00 with writedata 0xA5 -> mem_we = 0, led = 0xA5, and a read returns 0x000000A5.
REQ-030 FIFO fill: with tx_ready = 0, push 0x11, 0x22, 0x33, 0x44, 0x55 -> STATUS = 0x22 (full, count 4); 0x55 dropped. Then tx_ready = 1 -> tx_data sequence 0x11, 0x22, 0x33, 0x44, then tx_valid = 0 and STATUS = 0x01.
REQ-031 FIFO full with simultaneous push and pop: push 0x66 while full and tx_ready = 1 -> count stays 4, and 0x66 is output fifth.
REQ-032 Timer: COMPARE = 3, CTRL = 0x3 -> timer reads 0, 1, 2, 3, 0, ...; tflag = 1 and irq = 1 on the cycle after timer = 3. A STATUS write of 0x4 -> irq = 0.
REQ-033 Timer write priority: write TIMER = 3 on the cycle where count == COMPARE = 3 -> timer = 3, tflag = 1. Set-wins rule: STATUS clear in the same cycle as a match -> tflag remains 1.
REQ-034 Asynchronous reset: assert reset with the FIFO holding 2 entries, led = 0xFF, timer running -> immediately tx_valid = 0, led = 0, irq = 0. After deassertion, COMPARE reads 0xFFFFFFFF.

Source files
------------

// File: rtl/mmio_periph.sv
// Memory-mapped IO block: address decode, LED register, 4-deep TX byte FIFO,
// and a compare-match timer with sticky flag and interrupt.
module mmio_periph (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_TXDATA = 6'h01;
  localparam logic [5:0] OFF_STATUS = 6'h02;
  localparam logic [5:0] OFF_TIMER  = 6'h03;
  localparam logic [5:0] OFF_CMP    = 6'h04;
  localparam logic [5:0] OFF_CTRL   = 6'h05;

  typedef struct packed {
    logic       sel;
    logic       wr;
    logic [5:0] off;
  } io_req_t;

  io_req_t     req;
  logic [31:0] io_rdata;
  logic        unused_adr;

  assign req.sel    = (adr[31:8] == 24'hFFFFFF);
  assign req.off    = adr[7:2];
  assign req.wr     = memwrite & req.sel;
  assign unused_adr = ^adr[1:0];

  assign mem_we = memwrite & ~req.sel;

  logic wr_led, wr_tx, wr_status, wr_timer, wr_cmp, wr_ctrl;
  assign wr_led    = req.wr && (req.off == OFF_LED);
  assign wr_tx     = req.wr && (req.off == OFF_TXDATA);
  assign wr_status = req.wr && (req.off == OFF_STATUS);
  assign wr_timer  = req.wr && (req.off == OFF_TIMER);
  assign wr_cmp    = req.wr && (req.off == OFF_CMP);
  assign wr_ctrl   = req.wr && (req.off == OFF_CTRL);

  // LED register
  logic [7:0] led_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       led_q <= '0;
    else if (wr_led) led_q <= writedata[7:0];
  end
  assign led = led_q;

  // TX FIFO: a full FIFO still accepts a push when a pop frees a slot that cycle
  logic [7:0] fifo_q [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic       pop, push_ok, empty, full;

  assign empty   = (cnt == 3'd0);
  assign full    = (cnt == 3'd4);
  assign pop     = tx_valid & tx_ready;
  assign push_ok = wr_tx & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 2'd1;
      if (pop)     rp <= rp + 2'd1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wp] <= writedata[7:0];
  end

  assign tx_valid = ~empty;
  assign tx_data  = fifo_q[rp];

  // Timer, compare, control, sticky flag
  logic [31:0] timer_q, cmp_q, timer_nxt;
  logic        ten_q, ien_q, tflag_q, irq_q;
  logic        match, tflag_nxt, ien_nxt;

  assign match = ten_q && (timer_q == cmp_q);

  always_comb begin
    timer_nxt = timer_q;
    if (wr_timer)   timer_nxt = writedata;
    else if (match) timer_nxt = '0;
    else if (ten_q) timer_nxt = timer_q + 32'd1;
  end

  // Match set takes precedence over a software clear in the same cycle
  always_comb begin
    tflag_nxt = tflag_q;
    if (match)                        tflag_nxt = 1'b1;
    else if (wr_status && writedata[2]) tflag_nxt = 1'b0;
  end

  assign ien_nxt = wr_ctrl ? writedata[1] : ien_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      cmp_q   <= 32'hFFFFFFFF;
      ten_q   <= 1'b0;
      ien_q   <= 1'b0;
      tflag_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      timer_q <= timer_nxt;
      if (wr_cmp)  cmp_q <= writedata;
      if (wr_ctrl) ten_q <= writedata[0];
      ien_q   <= ien_nxt;
      tflag_q <= tflag_nxt;
      irq_q   <= tflag_nxt & ien_nxt;
    end
  end
  assign irq = irq_q;

  // Register read mux: pure function of address, no side effects
  always_comb begin
    io_rdata = '0;
    case (req.off)
      OFF_LED:    io_rdata = {24'h0, led_q};
      OFF_STATUS: io_rdata = {26'h0, cnt, tflag_q, full, empty};
      OFF_TIMER:  io_rdata = timer_q;
      OFF_CMP:    io_rdata = cmp_q;
      OFF_CTRL:   io_rdata = {30'h0, ien_q, ten_q};
      default:    io_rdata = '0;
    endcase
  end

  assign readdata = req.sel ? io_rdata : mem_rdata;

endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph: decode, FIFO fill/drain, timer match,
// flag priority and asynchronous reset, with hand-computed expectations.
module tb_mmio_periph;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr, writedata, readdata, mem_rdata;
  logic        memwrite, mem_we;
  logic [7:0]  led, tx_data;
  logic        tx_valid, tx_ready, irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_LED  = 32'hFFFFFF00;
  localparam logic [31:0] A_TX   = 32'hFFFFFF04;
  localparam logic [31:0] A_STAT = 32'hFFFFFF08;
  localparam logic [31:0] A_TMR  = 32'hFFFFFF0C;
  localparam logic [31:0] A_CMP  = 32'hFFFFFF10;
  localparam logic [31:0] A_CTRL = 32'hFFFFFF14;

  mmio_periph dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .readdata(readdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .led(led), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .irq(irq)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; the store lands on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; writedata = d; memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    adr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fill [5];
    logic [7:0] drain [4];
    reset = 1'b1; adr = '0; writedata = '0; memwrite = 1'b0;
    mem_rdata = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_txv", {31'h0, tx_valid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    rd("rst_status", A_STAT, 32'h1);
    rd("rst_cmp", A_CMP, 32'hFFFFFFFF);
    rd("rst_timer", A_TMR, 32'h0);
    rd("rst_ctrl", A_CTRL, 32'h0);

    // Decode
    mem_rdata = 32'h12345678;
    rd("mem_read", 32'h00000040, 32'h12345678);
    memwrite = 1'b1; #1;
    chk("mem_we_mem", {31'h0, mem_we}, 32'h1);
    memwrite = 1'b0;
    adr = A_LED; writedata = 32'hFFFFFFA5; memwrite = 1'b1; #1;
    chk("mem_we_io", {31'h0, mem_we}, 32'h0);
    @(negedge clk); memwrite = 1'b0;
    chk("led_out", {24'h0, led}, 32'hA5);
    rd("led_read_lowbits", 32'hFFFFFF03, 32'hA5);
    wr(32'hFFFFFF18, 32'hDEADBEEF);
    rd("unmapped_read", 32'hFFFFFF18, 32'h0);
    rd("led_untouched", A_LED, 32'hA5);
    rd("cmp_untouched", A_CMP, 32'hFFFFFFFF);
    rd("txdata_read", A_TX, 32'h0);

    // FIFO fill, drop on full, drain
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) wr(A_TX, {24'h0, fill[i]});
    rd("fill_status", A_STAT, 32'h22);
    chk("fill_head", {24'h0, tx_data}, 32'h11);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_data", {24'h0, tx_data}, {24'h0, fill[i]});
      chk("drain_valid", {31'h0, tx_valid}, 32'h1);
      @(negedge clk);
    end
    #1;
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd("drain_status", A_STAT, 32'h01);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) wr(A_TX, 32'hA1 + i);
    rd("full2_status", A_STAT, 32'h22);
    adr = A_TX; writedata = 32'h66; memwrite = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    memwrite = 1'b0; tx_ready = 1'b0;
    rd("pushpop_status", A_STAT, 32'h22);
    drain = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pushpop_data", {24'h0, tx_data}, {24'h0, drain[i]});
      @(negedge clk);
    end
    #1;
    chk("pushpop_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Timer match sequence and flag clear
    wr(A_CMP, 32'h3);
    rd("tmr_idle", A_TMR, 32'h0);
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) begin
      rd("tmr_count", A_TMR, i);
      @(negedge clk);
    end
    rd("tmr_wrap", A_TMR, 32'h0);
    chk("tmr_irq_set", {31'h0, irq}, 32'h1);
    rd("tmr_status_flag", A_STAT, 32'h05);
    rd("tmr_ctrl", A_CTRL, 32'h3);
    wr(A_STAT, 32'h4);
    chk("tmr_irq_clr", {31'h0, irq}, 32'h0);
    rd("tmr_status_clr", A_STAT, 32'h01);
    rd("tmr_after_clr", A_TMR, 32'h1);

    // Timer write on a match cycle, then clear colliding with a match
    @(negedge clk);
    @(negedge clk);
    rd("tmr_at_match", A_TMR, 32'h3);
    wr(A_TMR, 32'h3);
    rd("tmr_write_wins", A_TMR, 32'h3);
    rd("tmr_write_flag", A_STAT, 32'h05);
    chk("tmr_write_irq", {31'h0, irq}, 32'h1);
    wr(A_STAT, 32'h4);
    rd("set_wins_flag", A_STAT, 32'h05);
    chk("set_wins_irq", {31'h0, irq}, 32'h1);
    rd("set_wins_wrap", A_TMR, 32'h0);
    wr(A_STAT, 32'h4);
    rd("clr_again", A_STAT, 32'h01);
    wr(A_CTRL, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rd("tmr_hold", A_TMR, 32'h2);

    // Asynchronous reset mid-operation
    wr(A_TMR, 32'h0);
    wr(A_CMP, 32'h2);
    wr(A_TX, 32'hB1);
    wr(A_TX, 32'hB2);
    wr(A_LED, 32'hFF);
    wr(A_CTRL, 32'h3);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    chk("pre_rst_txv", {31'h0, tx_valid}, 32'h1);
    chk("pre_rst_led", {24'h0, led}, 32'hFF);
    adr = A_LED; writedata = 32'h5A; memwrite = 1'b1;
    #10;
    reset = 1'b1;
    #1;
    chk("arst_txv", {31'h0, tx_valid}, 32'h0);
    chk("arst_led", {24'h0, led}, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    adr = 32'h00000040; #1;
    chk("arst_mem_we", {31'h0, mem_we}, 32'h1);
    adr = A_LED;
    @(negedge clk);
    memwrite = 1'b0;
    #1;
    chk("arst_inflight", {24'h0, led}, 32'h0);
    reset = 1'b0;
    rd("post_rst_cmp", A_CMP, 32'hFFFFFFFF);
    rd("post_rst_timer", A_TMR, 32'h0);
    rd("post_rst_status", A_STAT, 32'h01);
    wr(A_LED, 32'h3C);
    chk("first_write", {24'h0, led}, 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
